// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// fetches words from instruction memory over a req/ack handshake, and hands
// them to decode through the IF/ID register. A one-entry skid buffer absorbs
// the word that completes while decode is stalled, so a zero-wait memory
// sustains one instruction per cycle without losing or repeating a word.
// A taken branch/jump (redirect) flushes IF/ID and the skid buffer. It then
// restarts fetching at the target. If a fetch to the old path is still
// outstanding, it is allowed to finish and its data is thrown away.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   o_imemReq     fetch request (registered)
//   o_imemAddr    fetch address, word aligned (registered)
//   i_imemAck     fetch completes this cycle, i_imemData valid
//   i_imemData    instruction word returned by memory
//   i_stall       decode cannot accept, IF/ID must hold
//   i_redirect    branch/jump taken: flush and refetch from i_redirectPc
//   i_redirectPc  redirect target, bits [1:0] treated as zero
//   o_valid       IF/ID holds a valid instruction
//   o_instr       IF/ID instruction, zero (NOP) when not valid
//   o_pcPlus4     address of o_instr plus four
//   o_instrCode   {opcode, funct} for the control unit (combinational)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcPlus4,
    output logic [11:0] o_instrCode
);

    // Force word alignment even if the parameter is set carelessly.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // out of reset, no request yet
        ST_REQ  = 2'd1,   // request outstanding on the correct path
        ST_SKID = 2'd2,   // skid buffer full, waiting for decode to drain
        ST_DROP = 2'd3    // request outstanding on a flushed path
    } state_t;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic        valid_r, valid_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] pcp4_r, pcp4_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic [31:0] skid_pcp4_r, skid_pcp4_s;

    logic        slot_free_s;
    logic [31:0] target_s;
    logic [31:0] addr_inc_s;
    logic        redirect_lsb_unused_s;

    assign slot_free_s = ~valid_r | ~i_stall;
    assign target_s    = {i_redirectPc[31:2], 2'b00};
    assign addr_inc_s  = next_word(addr_r);

    // The two low target bits are architecturally ignored.
    assign redirect_lsb_unused_s = ^i_redirectPc[1:0];

    // Next-state and datapath update for the fetch FSM and IF/ID register.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        req_s        = req_r;
        addr_s       = addr_r;
        valid_s      = valid_r;
        instr_s      = instr_r;
        pcp4_s       = pcp4_r;
        skid_instr_s = skid_instr_r;
        skid_pcp4_s  = skid_pcp4_r;

        // IF/ID baseline: a redirect flushes it, a consumed entry empties it
        // (the state logic below may refill it in the same cycle), otherwise
        // decode is stalled on a valid entry and it holds.
        if (i_redirect) begin
            valid_s = 1'b0;
            instr_s = 32'h0000_0000;
        end else if (slot_free_s) begin
            valid_s = 1'b0;
            instr_s = 32'h0000_0000;
        end else begin
            valid_s = valid_r;
            instr_s = instr_r;
        end

        case (state_r)
            ST_IDLE: begin
                req_s   = 1'b1;
                state_s = ST_REQ;
                if (i_redirect) begin
                    pc_s   = target_s;
                    addr_s = target_s;
                end else begin
                    addr_s = pc_r;
                end
            end

            ST_REQ: begin
                if (i_imemAck) begin
                    if (i_redirect) begin
                        // Word belongs to the flushed path: drop it.
                        pc_s   = target_s;
                        addr_s = target_s;
                    end else if (slot_free_s) begin
                        valid_s = 1'b1;
                        instr_s = i_imemData;
                        pcp4_s  = addr_inc_s;
                        pc_s    = addr_inc_s;
                        addr_s  = addr_inc_s;
                    end else begin
                        // Decode is stalled: park the word and pause fetching.
                        skid_instr_s = i_imemData;
                        skid_pcp4_s  = addr_inc_s;
                        pc_s         = addr_inc_s;
                        req_s        = 1'b0;
                        state_s      = ST_SKID;
                    end
                end else begin
                    if (i_redirect) begin
                        // Address must stay stable until ack, so the old
                        // request runs to completion and is then discarded.
                        pc_s    = target_s;
                        state_s = ST_DROP;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
            end

            ST_SKID: begin
                if (i_redirect) begin
                    pc_s    = target_s;
                    req_s   = 1'b1;
                    addr_s  = target_s;
                    state_s = ST_REQ;
                end else if (!i_stall) begin
                    valid_s = 1'b1;
                    instr_s = skid_instr_r;
                    pcp4_s  = skid_pcp4_r;
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_SKID;
                end
            end

            ST_DROP: begin
                if (i_imemAck) begin
                    state_s = ST_REQ;
                    if (i_redirect) begin
                        pc_s   = target_s;
                        addr_s = target_s;
                    end else begin
                        addr_s = pc_r;
                    end
                end else begin
                    if (i_redirect) begin
                        // Latest redirect wins.
                        pc_s = target_s;
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean restart.
                state_s = ST_IDLE;
                req_s   = 1'b0;
                valid_s = 1'b0;
                instr_s = 32'h0000_0000;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC_ALIGNED;
            req_r        <= 1'b0;
            addr_r       <= RESET_PC_ALIGNED;
            valid_r      <= 1'b0;
            instr_r      <= 32'h0000_0000;
            pcp4_r       <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
            skid_pcp4_r  <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            req_r        <= req_s;
            addr_r       <= addr_s;
            valid_r      <= valid_s;
            instr_r      <= instr_s;
            pcp4_r       <= pcp4_s;
            skid_instr_r <= skid_instr_s;
            skid_pcp4_r  <= skid_pcp4_s;
        end
    end

    assign o_imemReq   = req_r;
    assign o_imemAddr  = addr_r;
    assign o_valid     = valid_r;
    assign o_instr     = instr_r;
    assign o_pcPlus4   = pcp4_r;
    assign o_instrCode = {instr_r[31:26], instr_r[5:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. The reference model treats the fetch
// stage as a two-deep instruction queue (IF/ID plus skid) fed by a single
// memory request that may be marked stale by a redirect. Directed scenarios
// pin the model with hand-computed values, then a long random run compares
// the DUT against the model every cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ack = 1'b0;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [11:0] instr_code;

    int errors = 0;
    int checks = 0;
    int data_mode = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imemReq    (imem_req),
        .o_imemAddr   (imem_addr),
        .i_imemAck    (ack),
        .i_imemData   (imem_data),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirectPc (redirect_pc),
        .o_valid      (valid),
        .o_instr      (instr),
        .o_pcPlus4    (pc_plus4),
        .o_instrCode  (instr_code)
    );

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
        if (mode == 0) return a | 32'h0000_0020;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = mem_word(imem_addr, data_mode);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        stale;     // outstanding request belongs to a flushed path
        logic [31:0] next_pc;   // where the correct path continues
        logic [1:0]  n;         // number of buffered instructions (0..2)
        logic [31:0] q0_i;
        logic [31:0] q0_p;
        logic [31:0] q1_i;
        logic [31:0] q1_p;
    } model_t;

    localparam model_t MODEL_RESET = '{req: 1'b0, addr: RESET_PC, stale: 1'b0,
                                       next_pc: RESET_PC, n: 2'd0,
                                       q0_i: 32'd0, q0_p: 32'd0, q1_i: 32'd0, q1_p: 32'd0};

    model_t m;

    function automatic model_t model_step(input model_t cur, input logic a,
                                          input logic [31:0] d, input logic st,
                                          input logic rd, input logic [31:0] tgt);
        model_t r;
        logic [31:0] t;
        r = cur;
        t = {tgt[31:2], 2'b00};
        if (rd) begin
            r.n = 2'd0;
            r.next_pc = t;
            if (cur.req && !a) begin
                r.stale = 1'b1;
            end else begin
                r.req = 1'b1;
                r.addr = t;
                r.stale = 1'b0;
            end
        end else begin
            if (r.n != 2'd0 && !st) begin
                r.q0_i = r.q1_i;
                r.q0_p = r.q1_p;
                r.n = r.n - 2'd1;
            end
            if (cur.req && a) begin
                if (cur.stale) begin
                    r.addr = cur.next_pc;
                    r.stale = 1'b0;
                end else begin
                    if (r.n == 2'd0) begin
                        r.q0_i = d;
                        r.q0_p = cur.addr + 32'd4;
                    end else begin
                        r.q1_i = d;
                        r.q1_p = cur.addr + 32'd4;
                    end
                    r.n = r.n + 2'd1;
                    r.next_pc = cur.addr + 32'd4;
                    if (r.n == 2'd2) r.req = 1'b0;
                    else r.addr = cur.addr + 32'd4;
                end
            end else if (!cur.req && r.n <= 2'd1) begin
                r.req = 1'b1;
                r.addr = r.next_pc;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= MODEL_RESET;
        else m <= model_step(m, ack, mem_word(m.addr, data_mode), stall, redirect, redirect_pc);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_instr;
        exp_instr = (m.n != 2'd0) ? m.q0_i : 32'h0;
        check("req", 32'(imem_req), 32'(m.req));
        if (m.req) check("addr", imem_addr, m.addr);
        check("valid", 32'(valid), 32'(m.n != 2'd0));
        check("instr", instr, exp_instr);
        if (m.n != 2'd0) check("pcplus4", pc_plus4, m.q0_p);
        check("code", 32'(instr_code), 32'({exp_instr[31:26], exp_instr[5:0]}));
    endtask

    // One clock; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] t);
        ack = a;
        stall = s;
        redirect = r;
        redirect_pc = t;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pcplus4", pc_plus4, 32'h0);

        // 1: release with ack tied high, data = addr | 0x20
        rst_n = 1'b1;
        data_mode = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t1_req", 32'(imem_req), 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid_early", 32'(valid), 32'h0);
        tick();
        check("t1_valid", 32'(valid), 32'h1);
        check("t1_instr0", instr, 32'h0000_0020);
        check("t1_pcp4_0", pc_plus4, 32'h4);
        check("t1_code", 32'(instr_code), 32'h020);
        check("t1_addr1", imem_addr, 32'h4);
        tick();
        check("t1_instr1", instr, 32'h0000_0024);
        check("t1_pcp4_1", pc_plus4, 32'h8);

        // 2: stall for three cycles while valid
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("t2_hold", instr, 32'h0000_0024);
        check("t2_req_off", 32'(imem_req), 32'h0);
        tick();
        tick();
        check("t2_hold3", instr, 32'h0000_0024);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t2_skid_out", instr, 32'h0000_0028);
        check("t2_skid_pcp4", pc_plus4, 32'hC);
        check("t2_req_on", 32'(imem_req), 32'h1);
        check("t2_addr", imem_addr, 32'hC);
        tick();
        check("t2_contig", instr, 32'h0000_002C);

        // 3: redirect without ack, old request completes and is discarded
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        tick();
        check("t3_valid", 32'(valid), 32'h0);
        check("t3_instr", instr, 32'h0);
        check("t3_addr_old", imem_addr, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t3_addr_hold", imem_addr, 32'h10);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t3_discard", 32'(valid), 32'h0);
        check("t3_addr_new", imem_addr, 32'h100);
        tick();
        check("t3_instr_new", instr, 32'h0000_0120);
        check("t3_pcp4_new", pc_plus4, 32'h104);

        // 4: redirect in the same cycle as ack
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        tick();
        check("t4_valid", 32'(valid), 32'h0);
        check("t4_addr", imem_addr, 32'h200);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t4_instr", instr, 32'h0000_0220);
        check("t4_pcp4", pc_plus4, 32'h204);

        // 5: wrap at the top of the address space
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t5_instr", instr, 32'hFFFF_FFFC);
        check("t5_pcp4", pc_plus4, 32'h0);
        check("t5_addr_wrap", imem_addr, 32'h0);
        check("t5_code", 32'(instr_code), 32'hFFC);

        // Random run against the model
        data_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            ack = ($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0;
            stall = ($urandom_range(99, 0) < 30) ? 1'b1 : 1'b0;
            redirect = ($urandom_range(99, 0) < 6) ? 1'b1 : 1'b0;
            redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                      : $urandom();
            tick();
        end

        // 6: reset asserted while in DROP
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        tick();
        check("t6_drop_req", 32'(imem_req), 32'h1);
        check("t6_drop_valid", 32'(valid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(imem_req), 32'h0);
        check("t6_async_addr", imem_addr, RESET_PC);
        check("t6_async_valid", 32'(valid), 32'h0);
        check("t6_async_instr", instr, 32'h0);
        check("t6_async_pcp4", pc_plus4, 32'h0);
        check("t6_async_code", 32'(instr_code), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        data_mode = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("t6_first_req", 32'(imem_req), 32'h1);
        check("t6_first_addr", imem_addr, RESET_PC);
        tick();
        check("t6_first_instr", instr, 32'h0000_0020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
